// File: rtl/trigger_check_ctrl.sv
// Orbit-synchronous flash-bit search/lock/check controller with per-orbit hit/miss pulses.
// Build option: define TRIGCHK_ERRCNT_EN to include the saturating errCnt and clr_err logic.
module trigger_check_ctrl #(
  parameter int ORBIT_LEN   = 3564,
  parameter int LOCK_ORBITS = 4,
  parameter int MISS_LIMIT  = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        clr_err,
  input  logic        trigger,
  output logic        synched,
  output logic        flashBitFlag,
  output logic        error,
  output logic [11:0] flashBx,
  output logic [15:0] errCnt,
  output logic [1:0]  state
);

  localparam int MATCH_W = $clog2(LOCK_ORBITS) + 1;
  localparam int MISS_W  = $clog2(MISS_LIMIT) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [11:0]          bx_cnt_q, bx_cnt_d;
  logic [11:0]          flash_bx_q, flash_bx_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d, match_inc;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d, miss_inc;
  logic                 synched_q, synched_d;
  logic                 flag_q, flag_d;
  logic                 error_q, error_d;
  logic                 err_inc;
  logic                 check_pt;

  assign match_inc = match_cnt_q + 1'b1;
  assign miss_inc  = miss_cnt_q + 1'b1;
  assign check_pt  = (bx_cnt_q == flash_bx_q);

  always_comb begin
    bx_cnt_d    = (bx_cnt_q == 12'(ORBIT_LEN - 1)) ? 12'd0 : bx_cnt_q + 12'd1;
    state_d     = state_q;
    flash_bx_d  = flash_bx_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    flag_d      = 1'b0;
    error_d     = 1'b0;
    err_inc     = 1'b0;

    if (!enable) begin
      state_d     = IDLE;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = SEARCH;
        SEARCH: begin
          if (trigger) begin
            flash_bx_d  = bx_cnt_q;
            match_cnt_d = '0;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          // Only the candidate BX matters; physics triggers elsewhere are legal.
          if (check_pt) begin
            if (trigger) begin
              match_cnt_d = match_inc;
              if (match_inc == MATCH_W'(LOCK_ORBITS)) begin
                state_d    = LOCKED;
                miss_cnt_d = '0;
              end
            end else begin
              state_d = SEARCH;
            end
          end
        end
        LOCKED: begin
          if (check_pt) begin
            if (trigger) begin
              flag_d     = 1'b1;
              miss_cnt_d = '0;
            end else begin
              error_d    = 1'b1;
              err_inc    = 1'b1;
              miss_cnt_d = miss_inc;
              if (miss_inc == MISS_W'(MISS_LIMIT)) state_d = SEARCH;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    synched_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      bx_cnt_q    <= '0;
      flash_bx_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      synched_q   <= 1'b0;
      flag_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bx_cnt_q    <= bx_cnt_d;
      flash_bx_q  <= flash_bx_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      synched_q   <= synched_d;
      flag_q      <= flag_d;
      error_q     <= error_d;
    end
  end

`ifdef TRIGCHK_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Clear takes priority over a coincident increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err)                             err_cnt_d = 16'd0;
    else if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_cnt_q <= 16'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign errCnt = err_cnt_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = clr_err ^ err_inc;
  assign errCnt = 16'd0;
`endif

  assign state        = state_q;
  assign synched      = synched_q;
  assign flashBitFlag = flag_q;
  assign error        = error_q;
  assign flashBx      = flash_bx_q;

endmodule

// File: tb/tb_trigger_check_ctrl.sv
// Scoreboard bench for trigger_check_ctrl: expected hit/miss pulses are queued as stimulus is driven.
module tb_trigger_check_ctrl;

  localparam int L = 3564;

  logic        clk = 1'b0;
  logic        rstn, enable, clr_err, trigger;
  logic        synched, flashBitFlag, error;
  logic [11:0] flashBx;
  logic [15:0] errCnt;
  logic [1:0]  state;

  trigger_check_ctrl dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clr_err(clr_err), .trigger(trigger),
    .synched(synched), .flashBitFlag(flashBitFlag), .error(error),
    .flashBx(flashBx), .errCnt(errCnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_err; int bx; } ev_t;
  ev_t exp_q[$];
  ev_t ev_cur;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          bx = 0;
  logic [15:0] exp_err = 16'd0;

  function automatic logic [15:0] exp_errcnt();
`ifdef TRIGCHK_ERRCNT_EN
    return exp_err;
`else
    return 16'd0;
`endif
  endfunction

  // Pulse monitor: every flag/error pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rstn === 1'b1 && (flashBitFlag === 1'b1 || error === 1'b1)) begin
      n_cmp++;
      if (flashBitFlag && error) begin
        n_mis++;
        $display("FAIL pulse_excl: got flag=1 error=1 want at most one");
      end else if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL pulse_unexpected: got flag=%0b error=%0b at bx %0d want none", flashBitFlag, error, (bx + L - 1) % L);
      end else begin
        ev_cur = exp_q.pop_front();
        if (error !== ev_cur.is_err || ((bx + L - 1) % L) != ev_cur.bx) begin
          n_mis++;
          $display("FAIL pulse_kind: got err=%0b bx=%0d want err=%0b bx=%0d", error, (bx + L - 1) % L, ev_cur.is_err, ev_cur.bx);
        end else begin
          $display("pulse %s at bx %0d ok", ev_cur.is_err ? "error" : "flag", ev_cur.bx);
        end
      end
    end
  end

  task automatic tick(input logic t);
    trigger = t;
    @(posedge clk);
    #1;
    bx = (bx + 1) % L;
    trigger = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (bx != target) tick(1'b0);
  endtask

  task automatic expect_pulse(input bit is_err, input int b);
    ev_t e;
    e.is_err = is_err;
    e.bx = b;
    exp_q.push_back(e);
    if (is_err) begin
      if (clr_err) exp_err = 16'd0;
      else if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; enable = 1'b0; clr_err = 1'b0; trigger = 1'b0;
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({synched, flashBitFlag, error} !== 3'b000) begin
      n_mis++; $display("FAIL rst_flags: got %b want 000", {synched, flashBitFlag, error});
    end
    n_cmp++;
    if (state !== 2'd0 || flashBx !== 12'd0 || errCnt !== 16'd0) begin
      n_mis++; $display("FAIL rst_vals: got state=%0d bx=%0d err=%0d want 0/0/0", state, flashBx, errCnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    bx = 0;
    $display("reset released");
  endtask

  task automatic test_false_candidate();
    enable = 1'b1;
    tick(1'b0);
    n_cmp++;
    if (state !== 2'd1) begin n_mis++; $display("FAIL en_search: got %0d want 1", state); end
    run_to(50); tick(1'b1);
    n_cmp++;
    if (state !== 2'd2 || flashBx !== 12'd50) begin
      n_mis++; $display("FAIL cap50: got state=%0d bx=%0d want 2/50", state, flashBx);
    end
    run_to(100); tick(1'b1);
    n_cmp++;
    if (state !== 2'd2 || flashBx !== 12'd50) begin
      n_mis++; $display("FAIL ignore100: got state=%0d bx=%0d want 2/50", state, flashBx);
    end
    run_to(50); tick(1'b0);
    n_cmp++;
    if (state !== 2'd1) begin n_mis++; $display("FAIL drop50: got %0d want 1", state); end
    run_to(100); tick(1'b1);
    n_cmp++;
    if (state !== 2'd2 || flashBx !== 12'd100) begin
      n_mis++; $display("FAIL cap100: got state=%0d bx=%0d want 2/100", state, flashBx);
    end
  endtask

  task automatic test_lock();
    for (int o = 1; o <= 4; o++) begin
      run_to(100); tick(1'b1);
      n_cmp++;
      if (o < 4 && (state !== 2'd2 || synched !== 1'b0)) begin
        n_mis++; $display("FAIL verify_o%0d: got state=%0d synched=%0b want 2/0", o, state, synched);
      end else if (o == 4 && (state !== 2'd3 || synched !== 1'b1 || flashBx !== 12'd100)) begin
        n_mis++; $display("FAIL locked: got state=%0d synched=%0b bx=%0d want 3/1/100", state, synched, flashBx);
      end
      if (o < 4) begin
        run_to(2000); tick(1'b1);
        n_cmp++;
        if (state !== 2'd2 || flashBx !== 12'd100) begin
          n_mis++; $display("FAIL phys_ign_o%0d: got state=%0d bx=%0d want 2/100", o, state, flashBx);
        end
      end
    end
    run_to(300); tick(1'b1);
    expect_pulse(1'b0, 100);
    run_to(100); tick(1'b1);
    n_cmp++;
    if (synched !== 1'b1 || errCnt !== exp_errcnt()) begin
      n_mis++; $display("FAIL lock_hit: got synched=%0b err=%0d want 1/%0d", synched, errCnt, exp_errcnt());
    end
  endtask

  task automatic test_single_miss();
    expect_pulse(1'b1, 100);
    run_to(100); tick(1'b0);
    n_cmp++;
    if (synched !== 1'b1 || state !== 2'd3 || errCnt !== exp_errcnt()) begin
      n_mis++; $display("FAIL miss1: got synched=%0b state=%0d err=%0d want 1/3/%0d", synched, state, errCnt, exp_errcnt());
    end
    expect_pulse(1'b0, 100);
    run_to(100); tick(1'b1);
  endtask

  task automatic test_loss();
    expect_pulse(1'b1, 100);
    run_to(100); tick(1'b0);
    n_cmp++;
    if (synched !== 1'b1) begin n_mis++; $display("FAIL loss_first: got synched=%0b want 1", synched); end
    expect_pulse(1'b1, 100);
    run_to(100); tick(1'b0);
    n_cmp++;
    if (synched !== 1'b0 || state !== 2'd1 || errCnt !== exp_errcnt()) begin
      n_mis++; $display("FAIL loss: got synched=%0b state=%0d err=%0d want 0/1/%0d", synched, state, errCnt, exp_errcnt());
    end
  endtask

  task automatic test_wrap_saturation();
    run_to(L - 1); tick(1'b1);
    n_cmp++;
    if (state !== 2'd2 || flashBx !== 12'(L - 1)) begin
      n_mis++; $display("FAIL cap_wrap: got state=%0d bx=%0d want 2/%0d", state, flashBx, L - 1);
    end
    for (int o = 1; o <= 4; o++) begin
      run_to(L - 1); tick(1'b1);
    end
    n_cmp++;
    if (state !== 2'd3 || synched !== 1'b1) begin
      n_mis++; $display("FAIL lock_wrap: got state=%0d synched=%0b want 3/1", state, synched);
    end
`ifdef TRIGCHK_ERRCNT_EN
    @(negedge clk);
    force dut.err_cnt_q = 16'hFFFF;
    tick(1'b0);
    release dut.err_cnt_q;
    exp_err = 16'hFFFF;
`endif
    expect_pulse(1'b1, L - 1);
    run_to(L - 1); tick(1'b0);
    n_cmp++;
    if (errCnt !== exp_errcnt() || synched !== 1'b1) begin
      n_mis++; $display("FAIL sat: got err=%0h synched=%0b want %0h/1", errCnt, synched, exp_errcnt());
    end
    expect_pulse(1'b0, L - 1);
    run_to(L - 1); tick(1'b1);
    run_to(L - 1);
    clr_err = 1'b1;
    expect_pulse(1'b1, L - 1);
    tick(1'b0);
    clr_err = 1'b0;
    n_cmp++;
    if (errCnt !== 16'd0 || state !== 2'd3) begin
      n_mis++; $display("FAIL clr_win: got err=%0h state=%0d want 0/3", errCnt, state);
    end
  endtask

  task automatic test_reset_enable_mid();
    run_to(1000);
    #3 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({synched, flashBitFlag, error, state, flashBx, errCnt} !== '0) begin
      n_mis++; $display("FAIL async_rst: got synched=%0b state=%0d bx=%0d err=%0d want all 0", synched, state, flashBx, errCnt);
    end
    exp_err = 16'd0;
    @(negedge clk);
    rstn = 1'b1;
    bx = 0;
    tick(1'b0);
    run_to(20); tick(1'b1);
    n_cmp++;
    if (state !== 2'd2 || flashBx !== 12'd20) begin
      n_mis++; $display("FAIL recap20: got state=%0d bx=%0d want 2/20", state, flashBx);
    end
    run_to(40);
    enable = 1'b0;
    tick(1'b0);
    n_cmp++;
    if (state !== 2'd0 || flashBx !== 12'd20 || synched !== 1'b0) begin
      n_mis++; $display("FAIL dis_idle: got state=%0d bx=%0d synched=%0b want 0/20/0", state, flashBx, synched);
    end
    enable = 1'b1;
    tick(1'b0);
    n_cmp++;
    if (state !== 2'd1) begin n_mis++; $display("FAIL reen: got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_false_candidate();
    test_lock();
    test_single_miss();
    test_loss();
    test_wrap_saturation();
    test_reset_enable_mid();
    repeat (2) tick(1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL pulses_missing: got %0d outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
